// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared types and defaults for the windowed watchdog timer.
//   wdt_state_e             : FSM state encoding (IDLE=0, RUN=1, EXPIRED=2),
//                             visible on the top-level `state` port.
//   WDT_CNT_W_DEFAULT       : default counter / threshold width.
//   WDT_RST_PULSE_DEFAULT   : default system-reset pulse length in cycles.
//   WDT_WIN_DEFAULT_EN      : default reset value of the window-mode latch.
// -----------------------------------------------------------------------------
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } wdt_state_e;

    localparam int WDT_CNT_W_DEFAULT     = 16;
    localparam int WDT_RST_PULSE_DEFAULT = 8;
    localparam bit WDT_WIN_DEFAULT_EN    = 1'b0;

endpackage

// File: rtl/wdt_pulse_stretch.sv
// -----------------------------------------------------------------------------
// wdt_pulse_stretch
// Turns a one-cycle start strobe into an output held high for exactly
// RST_PULSE clock cycles, beginning on the edge that samples start_i.
// A start while the pulse is already running is ignored (no re-trigger).
// clear_i truncates a running pulse immediately on the next edge.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset; drops pulse_o at once
//   start_i  in  begin a pulse
//   clear_i  in  abort any pulse (wins over start_i)
//   pulse_o  out stretched pulse
// -----------------------------------------------------------------------------
module wdt_pulse_stretch #(
    parameter int RST_PULSE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic pulse_o
);

    // One extra bit of headroom keeps the counter at least 1 bit wide when
    // RST_PULSE is 1.
    localparam int CW = $clog2(RST_PULSE + 1);
    localparam logic [CW-1:0] LAST = CW'(RST_PULSE - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of high cycles still to come after the current one.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_i && !active_q) begin
            active_d = 1'b1;
            cnt_d    = LAST;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse_o = active_q;

endmodule

// File: rtl/wdt_window_timer.sv
// -----------------------------------------------------------------------------
// wdt_window_timer
// Windowed watchdog: CNT_W-bit up-counter with programmable timeout, early
// warning threshold, optional windowed-kick mode, sticky lock and a stretched
// system-reset pulse.
// Ports:
//   clk             in  sole clock, rising edge
//   rst_n           in  asynchronous active-low reset
//   enable          in  run request (level)
//   restart         in  kick, sampled every cycle
//   timeout_val     in  expiry count (0 behaves as 1)
//   warn_val        in  warning threshold
//   window_val      in  earliest legal kick count in window mode
//   window_en       in  windowed-kick mode request
//   lock            in  pulse; forces enable high until rst_n
//   timeout         out sticky expiry flag
//   warn            out count >= warning threshold while running
//   early_kick_err  out sticky; expiry caused by an early kick
//   wdt_rst         out system reset pulse, RST_PULSE cycles
//   count           out current counter value
//   state           out FSM state (IDLE=0, RUN=1, EXPIRED=2)
// -----------------------------------------------------------------------------
module wdt_window_timer
    import wdt_pkg::*;
#(
    parameter int CNT_W          = WDT_CNT_W_DEFAULT,
    parameter int RST_PULSE      = WDT_RST_PULSE_DEFAULT,
    parameter bit WIN_DEFAULT_EN = WDT_WIN_DEFAULT_EN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic [CNT_W-1:0] warn_val,
    input  logic [CNT_W-1:0] window_val,
    input  logic             window_en,
    input  logic             lock,
    output logic             timeout,
    output logic             warn,
    output logic             early_kick_err,
    output logic             wdt_rst,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state
);

    wdt_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] warn_thr_q, warn_thr_d;
    logic [CNT_W-1:0] win_val_q, win_val_d;
    logic             win_en_q, win_en_d;
    logic             lock_q, lock_d;
    logic             timeout_q, timeout_d;
    logic             warn_q, warn_d;
    logic             early_q, early_d;

    logic             en_eff;
    logic             kick_ok;
    logic             pulse_start;
    logic             pulse_clear;
    logic [CNT_W-1:0] tmo_clamped;

    // Once locked, the enable pin no longer matters.
    assign en_eff      = enable | lock_q;
    assign tmo_clamped = (timeout_val == '0) ? CNT_W'(1) : timeout_val;
    assign kick_ok     = !win_en_q || (count_q >= win_val_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        warn_thr_d  = warn_thr_q;
        win_val_d   = win_val_q;
        win_en_d    = win_en_q;
        timeout_d   = timeout_q;
        early_d     = early_q;
        lock_d      = lock_q | lock;
        pulse_start = 1'b0;
        pulse_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d   = '0;
                timeout_d = 1'b0;
                early_d   = 1'b0;
                if (en_eff) begin
                    // Configuration is frozen for the whole run.
                    state_d    = ST_RUN;
                    tmo_d      = tmo_clamped;
                    warn_thr_d = warn_val;
                    win_val_d  = window_val;
                    win_en_d   = window_en;
                end
            end

            ST_RUN: begin
                // Priority: disable > early kick > valid kick > expiry > count.
                if (!en_eff) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    timeout_d   = 1'b0;
                    early_d     = 1'b0;
                    pulse_clear = 1'b1;
                end else if (restart && !kick_ok) begin
                    state_d     = ST_EXPIRED;
                    timeout_d   = 1'b1;
                    early_d     = 1'b1;
                    pulse_start = 1'b1;
                end else if (restart) begin
                    count_d = '0;
                end else if (count_q == tmo_q) begin
                    state_d     = ST_EXPIRED;
                    timeout_d   = 1'b1;
                    pulse_start = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            ST_EXPIRED: begin
                // Count frozen and kicks ignored; only a disable gets out.
                if (!en_eff) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    timeout_d   = 1'b0;
                    early_d     = 1'b0;
                    pulse_clear = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                count_d     = '0;
                timeout_d   = 1'b0;
                early_d     = 1'b0;
                pulse_clear = 1'b1;
            end
        endcase

        // Registered together with count so warn lines up with the count value.
        warn_d = (state_d == ST_RUN) && (count_d >= warn_thr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tmo_q      <= CNT_W'(1);
            warn_thr_q <= '0;
            win_val_q  <= '0;
            win_en_q   <= WIN_DEFAULT_EN;
            lock_q     <= 1'b0;
            timeout_q  <= 1'b0;
            warn_q     <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            warn_thr_q <= warn_thr_d;
            win_val_q  <= win_val_d;
            win_en_q   <= win_en_d;
            lock_q     <= lock_d;
            timeout_q  <= timeout_d;
            warn_q     <= warn_d;
            early_q    <= early_d;
        end
    end

    wdt_pulse_stretch #(
        .RST_PULSE (RST_PULSE)
    ) u_pulse (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (pulse_start),
        .clear_i (pulse_clear),
        .pulse_o (wdt_rst)
    );

    assign timeout        = timeout_q;
    assign warn           = warn_q;
    assign early_kick_err = early_q;
    assign count          = count_q;
    assign state          = state_q;

endmodule
